arb_rr_hold: RTL and testbench



---
 rtl/arb_rr_hold.sv | 138 +++++++++++++
 tb/tb_arb_rr_hold.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/arb_rr_hold.sv
// arb_rr_hold: N-way round-robin arbiter with grant hold and registered grant.
// Define ARB_RR_TIMEOUT_EN to compile in the MAX_HOLD forced-rotation limit.
module arb_rr_hold #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16,
  parameter int IW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  if (N < 2 || MAX_HOLD < 1) begin : g_bad_param
    $error("arb_rr_hold: N must be >= 2 and MAX_HOLD >= 1");
  end

  logic [IW-1:0] last;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic          found;
  logic [N-1:0]  mask;
  logic          holder_req;
  logic          expired;
  logic          keep;
  logic          new_grant;
  logic          nxt_valid;
  logic [IW-1:0] nxt_idx;
  logic [N-1:0]  nxt_gnt;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] a);
    return (a == IW'(N-1)) ? '0 : a + 1'b1;
  endfunction

`ifdef ARB_RR_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);

  logic [CW-1:0] hold_cnt;

  assign expired = (hold_cnt == CW'(MAX_HOLD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (!nxt_valid) begin
      hold_cnt <= '0;
    end else if (new_grant) begin
      hold_cnt <= CW'(1);
    end else if (!expired) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign expired = 1'b0;
`endif

  assign holder_req = gnt_valid && req[gnt_idx];
  assign keep       = holder_req && !expired;

  // On expiry the holder is masked out; last equals the holder here,
  // so the search naturally starts at holder+1.
  assign mask = (holder_req && expired) ? (req & ~gnt) : req;

  always_comb begin
    ptr   = wrap_inc(last);
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && mask[ptr]) begin
        found = 1'b1;
        win   = ptr;
      end
      ptr = wrap_inc(ptr);
    end
  end

  always_comb begin
    nxt_valid = 1'b0;
    nxt_idx   = '0;
    new_grant = 1'b0;
    priority case (1'b1)
      keep: begin
        nxt_valid = 1'b1;
        nxt_idx   = gnt_idx;
      end
      found: begin
        nxt_valid = 1'b1;
        nxt_idx   = win;
        new_grant = 1'b1;
      end
      holder_req: begin
        nxt_valid = 1'b1;
        nxt_idx   = gnt_idx;
        new_grant = 1'b1;
      end
      default: begin
        nxt_valid = 1'b0;
      end
    endcase
  end

  always_comb begin
    nxt_gnt = '0;
    for (int i = 0; i < N; i++) begin
      nxt_gnt[i] = nxt_valid && (nxt_idx == IW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      last      <= IW'(N-1);
    end else begin
      gnt       <= nxt_gnt;
      gnt_valid <= nxt_valid;
      gnt_idx   <= nxt_idx;
      if (new_grant) begin
        last <= nxt_idx;
      end
    end
  end

`ifndef SYNTHESIS
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt));
  a_valid: assert property (@(posedge clk) disable iff (!rst_n)
    gnt_valid == (|gnt));
  a_idx: assert property (@(posedge clk) disable iff (!rst_n)
    gnt_valid ? gnt[gnt_idx] : (gnt_idx == '0));
  a_last: assert property (@(posedge clk) disable iff (!rst_n)
    int'(last) < N);
`endif

endmodule

// File: tb/tb_arb_rr_hold.sv
// tb_arb_rr_hold: checks arb_rr_hold (N=8 and N=5) against a behavioural model.
// Expectations follow ARB_RR_TIMEOUT_EN when it is defined for the build.
module tb_arb_rr_hold;

`ifdef ARB_RR_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif
  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req8 = '0;
  logic [4:0] req5 = '0;
  logic [7:0] gnt8;
  logic [4:0] gnt5;
  logic       gnt_valid8, gnt_valid5;
  logic [2:0] gnt_idx8, gnt_idx5;

  int n_chk = 0;
  int n_err = 0;

  int m8_g = -1, m8_last = 7, m8_cnt = 0;
  int m5_g = -1, m5_last = 4, m5_cnt = 0;
  int g8, l8, c8, g5, l5, c5;
  int t8 [8];
  int t5 [5];

  always #5 clk = ~clk;

  arb_rr_hold #(.N(8), .MAX_HOLD(MAXH)) u8 (
    .clk(clk), .rst_n(rst_n), .req(req8),
    .gnt(gnt8), .gnt_valid(gnt_valid8), .gnt_idx(gnt_idx8)
  );

  arb_rr_hold #(.N(5), .MAX_HOLD(MAXH)) u5 (
    .clk(clk), .rst_n(rst_n), .req(req5),
    .gnt(gnt5), .gnt_valid(gnt_valid5), .gnt_idx(gnt_idx5)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Holder g (-1 = idle) and last-granted index, stepped once per cycle.
  function automatic void mstep(input int n, input logic [7:0] rq,
                                input int g, input int last, input int cnt,
                                output int ng, output int nl, output int nc);
    bit hr;
    bit ex;
    int st;
    int j;
    hr = (g >= 0) && rq[g];
    ex = TMO && (cnt >= MAXH);
    if (hr && !ex) begin
      ng = g;
      nl = last;
      nc = (cnt < MAXH) ? cnt + 1 : MAXH;
      return;
    end
    st = hr ? g : last;
    ng = -1;
    for (int i = 1; i <= n; i++) begin
      j = (st + i) % n;
      if (ng < 0 && rq[j] && !(hr && j == g)) ng = j;
    end
    if (ng < 0 && hr) ng = g;
    if (ng >= 0) begin
      nl = ng;
      nc = 1;
    end else begin
      nl = last;
      nc = 0;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8_g <= -1; m8_last <= 7; m8_cnt <= 0;
      m5_g <= -1; m5_last <= 4; m5_cnt <= 0;
    end else begin
      mstep(8, req8, m8_g, m8_last, m8_cnt, g8, l8, c8);
      mstep(5, {3'b000, req5}, m5_g, m5_last, m5_cnt, g5, l5, c5);
      m8_g <= g8; m8_last <= l8; m8_cnt <= c8;
      m5_g <= g5; m5_last <= l5; m5_cnt <= c5;
    end
  end

  always @(negedge clk) begin
    check("u8_gnt", int'(gnt8), (m8_g >= 0) ? (1 << m8_g) : 0);
    check("u8_valid", int'(gnt_valid8), int'(m8_g >= 0));
    check("u8_idx", int'(gnt_idx8), (m8_g >= 0) ? m8_g : 0);
    check("u5_gnt", int'(gnt5), (m5_g >= 0) ? (1 << m5_g) : 0);
    check("u5_valid", int'(gnt_valid5), int'(m5_g >= 0));
    check("u5_idx", int'(gnt_idx5), (m5_g >= 0) ? m5_g : 0);
  end

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req8 = '0;
    req5 = '0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    // 1: reset, then async reset while a grant is up
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_idle_gnt", int'(gnt8), 0);
    req8 = 8'h40;
    @(negedge clk);
    check("t1_first_gnt", int'(gnt8), 8'h40);
    check("t1_first_idx", int'(gnt_idx8), 6);
    #3;
    rst_n = 1'b0;
    req8 = '0;
    #1;
    check("t1_async_gnt", int'(gnt8), 0);
    check("t1_async_valid", int'(gnt_valid8), 0);
    check("t1_async_idx", int'(gnt_idx8), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t1_rel_gnt", int'(gnt8), 0);
      check("t1_rel_valid", int'(gnt_valid8), 0);
    end

    // 2: release hand-off
    do_reset();
    req8 = 8'h05;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t2_hold", int'(gnt8), 8'h01);
    end
    req8 = 8'h04;
    @(negedge clk);
    check("t2_handoff", int'(gnt8), 8'h04);
    check("t2_handoff_idx", int'(gnt_idx8), 2);

    // 3: fairness with requesters that drop and come back
    do_reset();
    for (int i = 0; i < 8; i++) t8[i] = 0;
    for (int i = 0; i < 5; i++) t5[i] = 0;
    req8 = 8'hFF;
    req5 = 5'h1F;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      #1;
      check("t3_order8", int'(gnt_idx8), c % 8);
      check("t3_valid8", int'(gnt_valid8), 1);
      if (c < 6) check("t3_order5", int'(gnt_idx5), c % 5);
      check("t3_range5", int'(int'(gnt_idx5) < 5), 1);
      for (int i = 0; i < 8; i++) begin
        if (t8[i] > 0) begin
          t8[i]--;
          if (t8[i] == 0) req8[i] = 1'b1;
        end else if (m8_g == i) begin
          req8[i] = 1'b0;
          t8[i] = 2;
        end
      end
      for (int i = 0; i < 5; i++) begin
        if (t5[i] > 0) begin
          t5[i]--;
          if (t5[i] == 0) req5[i] = 1'b1;
        end else if (m5_g == i) begin
          req5[i] = 1'b0;
          t5[i] = 2;
        end
      end
    end

    // 4: hold limit with two constant requesters
    do_reset();
    req8 = 8'h03;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("t4_limit", int'(gnt8), TMO ? ((((c / 4) % 2) != 0) ? 2 : 1) : 1);
    end

    // 5: lone requester never sees a gap
    do_reset();
    req8 = 8'h10;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("t5_lone", int'(gnt8), 8'h10);
    end

    // 6: reset while 0x08 holds, search restarts from 0
    do_reset();
    req8 = 8'h08;
    @(negedge clk);
    check("t6_pre", int'(gnt8), 8'h08);
    req8 = 8'h0C;
    @(negedge clk);
    check("t6_held", int'(gnt8), 8'h08);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_gnt", int'(gnt8), 0);
    check("t6_rst_valid", int'(gnt_valid8), 0);
    @(negedge clk);
    check("t6_rst_hold", int'(gnt8), 0);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_after", int'(gnt8), 8'h04);
    check("t6_after_idx", int'(gnt_idx8), 2);

    req8 = '0;
    repeat (2) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
